pilha_retorno: RTL and testbench
================================

PILHA_RETORNO -- requirements
Module: pilha_retorno

Interface
REQ-001 SHALL have parameter LARGURA, default 32: width of a stored return address in bits.
REQ-002 SHALL have parameter PROFUNDIDADE, default 16: number of stack entries, a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port push, input, 1 bit: the control unit requests storing end_entrada.
REQ-006 SHALL have port pop, input, 1 bit: the control unit requests removal of the top entry.
REQ-007 SHALL have port end_entrada, input, LARGURA bits: return address to push (PC of the jal successor).
REQ-008 SHALL have port topo, output, LARGURA bits: current top-of-stack value, fed to PC mux input 2'b11.
REQ-009 SHALL have port vazia, output, 1 bit: asserted when the stack holds 0 entries.
REQ-010 SHALL have port cheia, output, 1 bit: asserted when the stack holds PROFUNDIDADE entries.
REQ-011 SHALL have port ocupacao, output, clog2(PROFUNDIDADE)+1 bits: number of valid entries.
REQ-012 SHALL have port estouro, output, 1 bit: sticky flag for a push while full.
REQ-013 SHALL have port esvaziamento, output, 1 bit: sticky flag for a pop while empty.

Function
REQ-014 SHALL sample push and pop on the rising edge of clk; both are 1-cycle pulses from the control unit, issued on the falling edge.
REQ-015 SHALL drive topo registered and stable for the whole cycle, equal to the most recently pushed, not-yet-popped entry; it SHALL be 0 when the stack is empty.
REQ-016 SHALL keep topo valid for the entire pop cycle, so that PC captures the old top on the same rising edge on which the pop takes effect (zero-latency read, 1-cycle update).
REQ-017 SHALL, on a push when not full, store end_entrada, increment ocupacao, and present end_entrada on topo from the next cycle.
REQ-018 SHALL, on a pop when not empty, decrement ocupacao and present the next-older entry on topo from the next cycle, or 0 if the stack becomes empty.
REQ-019 SHALL, on push and pop together when not empty, replace the top entry with end_entrada and leave ocupacao unchanged.
REQ-020 SHALL, on push and pop together when empty, behave as a plain push and leave esvaziamento unchanged.
REQ-021 SHALL, on a push when full, discard end_entrada, leave contents and ocupacao unchanged, and set estouro.
REQ-022 SHALL, on a pop when empty, leave topo at 0 and ocupacao at 0, and set esvaziamento.
REQ-023 SHALL keep estouro and esvaziamento set until reset.
REQ-024 SHALL derive vazia and cheia combinationally from ocupacao: vazia is ocupacao==0 and cheia is ocupacao==PROFUNDIDADE.
REQ-025 SHALL wrap the stack pointer modulo PROFUNDIDADE internally, with occupancy held in the extra bit of ocupacao.

Reset
REQ-026 SHALL, while reset is low, immediately force ocupacao=0, topo=0, estouro=0 and esvaziamento=0, independent of clk.
REQ-027 SHALL leave storage array contents unreset; they SHALL never be visible on topo while their entries are invalid.
REQ-028 SHALL let reset asserted mid-sequence (for example between a jal push and a later jst pop) override any pending push or pop in that cycle.

Structure
REQ-029 SHALL take the LARGURA and PROFUNDIDADE defaults, and the PC mux code for stack select (2'b11), from the shared processor constants package used by the control unit and datapath.
REQ-030 SHALL place the storage in one sub-module, pilha_mem: a synchronous-write, asynchronous-read register array of PROFUNDIDADE x LARGURA.
REQ-031 SHALL keep the pointer, occupancy, topo register and flags in pilha_retorno itself.

Verification
REQ-032 SHALL cover: reset low, then push 0x10, push 0x20 -> topo=0x20, ocupacao=2; pop -> topo=0x10 in the same cycle the PC samples 0x20.
REQ-033 SHALL cover: 16 pushes of 1..16 -> cheia=1, topo=16; 17th push of 99 -> estouro=1, topo=16, ocupacao=16; 16 pops -> values 16..1 in order, vazia=1.
REQ-034 SHALL cover: pop on empty -> topo=0, esvaziamento=1, ocupacao=0; a later push of 0x5 -> topo=0x5, esvaziamento remains 1.
REQ-035 SHALL cover: push 0xA, then push+pop together with 0xB -> topo=0xB, ocupacao=1; push+pop on empty with 0xC -> topo=0xC, ocupacao=1.
REQ-036 SHALL cover: 3 pushes, then reset pulsed low between clock edges -> ocupacao=0, topo=0 and both flags 0 before the next edge; a push coinciding with reset low is ignored.
REQ-037 SHALL cover the system path: jal to 0x40 from PC 0x07 -> stack top=0x08; jst -> PC=0x08 and the stack empty.

Source files
------------

// File: rtl/pilha_retorno_pkg.sv
// Shared processor constants and return-stack operation codes.
// Imported by the control unit, datapath and the return address stack.
package pilha_retorno_pkg;

  localparam int LARGURA_PADRAO      = 32;
  localparam int PROFUNDIDADE_PADRAO = 16;
  localparam logic [1:0] PC_SEL_PILHA = 2'b11;

  typedef enum logic [2:0] {
    OP_NADA,
    OP_PUSH,
    OP_POP,
    OP_TROCA,
    OP_ESTOURO,
    OP_VAZIO
  } op_t;

endpackage

// File: rtl/pilha_retorno_mem.sv
// Return stack storage: synchronous write, asynchronous read.
// Contents are deliberately left unreset.
module pilha_mem #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 16,
  localparam int AW          = $clog2(PROFUNDIDADE)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [LARGURA-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [LARGURA-1:0] rdata
);

  logic [LARGURA-1:0] mem [PROFUNDIDADE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pilha_retorno.sv
// Return address stack for jal/jst: registered top, sticky error flags.
// The stack pointer is the low bits of ocupacao, wrapping modulo depth.
module pilha_retorno
  import pilha_retorno_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic                              pop,
  input  logic [LARGURA-1:0]                end_entrada,
  output logic [LARGURA-1:0]                topo,
  output logic                              vazia,
  output logic                              cheia,
  output logic [$clog2(PROFUNDIDADE):0]     ocupacao,
  output logic                              estouro,
  output logic                              esvaziamento
);

  localparam int AW = $clog2(PROFUNDIDADE);
  localparam int OW = AW + 1;

  op_t                op;
  logic [AW-1:0]      ptr;
  logic [AW-1:0]      waddr;
  logic [AW-1:0]      raddr;
  logic               we;
  logic [LARGURA-1:0] rdata;

  assign vazia = (ocupacao == '0);
  assign cheia = (ocupacao == OW'(PROFUNDIDADE));

  always_comb begin
    op = OP_NADA;
    unique case (1'b1)
      (push && pop && !vazia):               op = OP_TROCA;
      (push && !cheia && !(pop && !vazia)):  op = OP_PUSH;
      (push && !pop && cheia):               op = OP_ESTOURO;
      (!push && pop && !vazia):              op = OP_POP;
      (!push && pop && vazia):               op = OP_VAZIO;
      default:                               op = OP_NADA;
    endcase
  end

  // ptr names the next free slot; the top lives at ptr-1, the one below at ptr-2
  assign ptr   = ocupacao[AW-1:0];
  assign raddr = ptr - AW'(2);
  assign waddr = (op == OP_TROCA) ? ptr - AW'(1) : ptr;
  assign we    = (op == OP_PUSH) || (op == OP_TROCA);

  pilha_mem #(
    .LARGURA      (LARGURA),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (end_entrada),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ocupacao     <= '0;
      topo         <= '0;
      estouro      <= 1'b0;
      esvaziamento <= 1'b0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          ocupacao <= ocupacao + OW'(1);
          topo     <= end_entrada;
        end
        OP_TROCA: topo <= end_entrada;
        OP_POP: begin
          ocupacao <= ocupacao - OW'(1);
          topo     <= (ocupacao == OW'(1)) ? '0 : rdata;
        end
        OP_ESTOURO: estouro      <= 1'b1;
        OP_VAZIO:   esvaziamento <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pilha_retorno.sv
// Directed self-checking bench for pilha_retorno.
module tb_pilha_retorno;
  import pilha_retorno_pkg::*;

  logic        clk;
  logic        reset;
  logic        push;
  logic        pop;
  logic [31:0] end_entrada;
  logic [31:0] topo;
  logic        vazia;
  logic        cheia;
  logic [4:0]  ocupacao;
  logic        estouro;
  logic        esvaziamento;

  int errors = 0;
  int checks = 0;

  pilha_retorno dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .end_entrada  (end_entrada),
    .topo         (topo),
    .vazia        (vazia),
    .cheia        (cheia),
    .ocupacao     (ocupacao),
    .estouro      (estouro),
    .esvaziamento (esvaziamento)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ciclo(input logic p, input logic q, input logic [31:0] d);
    @(negedge clk);
    push = p;
    pop = q;
    end_entrada = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
  endtask

  task automatic pulso_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    end_entrada = '0;
    #3;
    checks++;
    if ({ocupacao, vazia, cheia, estouro, esvaziamento} !== {5'd0, 4'b1000})
      begin errors++; $display("FAIL reset_flags: ocup=%0d vazia=%b cheia=%b est=%b esv=%b, need 0 1 0 0 0", ocupacao, vazia, cheia, estouro, esvaziamento); end
    checks++;
    if (topo !== 32'h0) begin errors++; $display("FAIL reset_topo: got %h need 0", topo); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basico();
    ciclo(1, 0, 32'h10);
    ciclo(1, 0, 32'h20);
    checks++;
    if (topo !== 32'h20 || ocupacao !== 5'd2)
      begin errors++; $display("FAIL push2: topo=%h ocup=%0d need 20 2", topo, ocupacao); end
    @(negedge clk);
    pop = 1'b1;
    #1;
    checks++;
    if (topo !== 32'h20) begin errors++; $display("FAIL pop_old_top: got %h need 20", topo); end
    @(posedge clk);
    #1;
    pop = 1'b0;
    checks++;
    if (topo !== 32'h10 || ocupacao !== 5'd1)
      begin errors++; $display("FAIL pop_new_top: topo=%h ocup=%0d need 10 1", topo, ocupacao); end
    ciclo(0, 1, 0);
    checks++;
    if (topo !== 32'h0 || vazia !== 1'b1)
      begin errors++; $display("FAIL pop_to_empty: topo=%h vazia=%b need 0 1", topo, vazia); end
  endtask

  task automatic test_cheio();
    pulso_reset();
    for (int i = 1; i <= 16; i++) ciclo(1, 0, 32'(i));
    checks++;
    if (cheia !== 1'b1 || topo !== 32'd16)
      begin errors++; $display("FAIL full: cheia=%b topo=%0d need 1 16", cheia, topo); end
    ciclo(1, 0, 32'd99);
    checks++;
    if (estouro !== 1'b1 || topo !== 32'd16 || ocupacao !== 5'd16)
      begin errors++; $display("FAIL overflow: est=%b topo=%0d ocup=%0d need 1 16 16", estouro, topo, ocupacao); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (topo !== 32'(16 - i))
        begin errors++; $display("FAIL pop_order[%0d]: got %0d need %0d", i, topo, 16 - i); end
      ciclo(0, 1, 0);
    end
    checks++;
    if (vazia !== 1'b1 || topo !== 32'h0 || estouro !== 1'b1)
      begin errors++; $display("FAIL drained: vazia=%b topo=%h est=%b need 1 0 1", vazia, topo, estouro); end
  endtask

  task automatic test_pop_vazio();
    pulso_reset();
    ciclo(0, 1, 0);
    checks++;
    if (topo !== 32'h0 || esvaziamento !== 1'b1 || ocupacao !== 5'd0)
      begin errors++; $display("FAIL underflow: topo=%h esv=%b ocup=%0d need 0 1 0", topo, esvaziamento, ocupacao); end
    ciclo(1, 0, 32'h5);
    checks++;
    if (topo !== 32'h5 || esvaziamento !== 1'b1 || ocupacao !== 5'd1)
      begin errors++; $display("FAIL underflow_sticky: topo=%h esv=%b ocup=%0d need 5 1 1", topo, esvaziamento, ocupacao); end
  endtask

  task automatic test_troca();
    pulso_reset();
    ciclo(1, 0, 32'hA);
    ciclo(1, 1, 32'hB);
    checks++;
    if (topo !== 32'hB || ocupacao !== 5'd1)
      begin errors++; $display("FAIL replace: topo=%h ocup=%0d need b 1", topo, ocupacao); end
    ciclo(0, 1, 0);
    ciclo(1, 1, 32'hC);
    checks++;
    if (topo !== 32'hC || ocupacao !== 5'd1 || esvaziamento !== 1'b0)
      begin errors++; $display("FAIL pushpop_empty: topo=%h ocup=%0d esv=%b need c 1 0", topo, ocupacao, esvaziamento); end
  endtask

  task automatic test_reset_meio();
    pulso_reset();
    ciclo(1, 0, 32'h1);
    ciclo(1, 0, 32'h2);
    ciclo(0, 1, 0);
    ciclo(0, 1, 0);
    ciclo(0, 1, 0);
    checks++;
    if (esvaziamento !== 1'b1) begin errors++; $display("FAIL pre_reset_flag: esv=%b need 1", esvaziamento); end
    ciclo(1, 0, 32'h3);
    ciclo(1, 0, 32'h4);
    ciclo(1, 0, 32'h5);
    @(negedge clk);
    push = 1'b1;
    end_entrada = 32'h77;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({ocupacao, estouro, esvaziamento} !== 7'd0 || topo !== 32'h0)
      begin errors++; $display("FAIL async_reset: ocup=%0d topo=%h est=%b esv=%b need 0 0 0 0", ocupacao, topo, estouro, esvaziamento); end
    @(posedge clk);
    #1;
    checks++;
    if (ocupacao !== 5'd0 || topo !== 32'h0)
      begin errors++; $display("FAIL push_in_reset: ocup=%0d topo=%h need 0 0", ocupacao, topo); end
    push = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ciclo(0, 0, 0);
    checks++;
    if (vazia !== 1'b1 || topo !== 32'h0)
      begin errors++; $display("FAIL after_reset: vazia=%b topo=%h need 1 0", vazia, topo); end
  endtask

  task automatic test_sistema();
    logic [31:0] pc;
    logic [31:0] pc_prox;
    logic [1:0]  sel;
    pulso_reset();
    pc = 32'h07;
    @(negedge clk);
    push = 1'b1;
    end_entrada = pc + 32'd1;
    pc_prox = 32'h40;
    @(posedge clk);
    pc = pc_prox;
    #1;
    push = 1'b0;
    checks++;
    if (topo !== 32'h08 || pc !== 32'h40)
      begin errors++; $display("FAIL jal: topo=%h pc=%h need 08 40", topo, pc); end
    @(negedge clk);
    pop = 1'b1;
    sel = PC_SEL_PILHA;
    pc_prox = (sel == 2'b11) ? topo : pc + 32'd1;
    @(posedge clk);
    pc = pc_prox;
    #1;
    pop = 1'b0;
    checks++;
    if (pc !== 32'h08 || vazia !== 1'b1 || topo !== 32'h0)
      begin errors++; $display("FAIL jst: pc=%h vazia=%b topo=%h need 08 1 0", pc, vazia, topo); end
  endtask

  initial begin
    test_reset();
    test_basico();
    test_cheio();
    test_pop_vazio();
    test_troca();
    test_reset_meio();
    test_sistema();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
